// File: rtl/store_buffer_if.sv
// Store buffer port bundle: MEM-stage store/load lookup side plus data cache write side.
// The slave modport is the buffer itself; master is the pipeline/cache environment.
interface store_buffer_if #(
    parameter int AW    = 32,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          st_valid_i;
    logic [AW-1:0] st_addr_i;
    logic [31:0]   st_data_i;
    logic [1:0]    st_type_i;
    logic          st_ready_o;

    logic [AW-1:0] ld_addr_i;
    logic [31:0]   ld_fwd_data_o;
    logic [3:0]    ld_fwd_mask_o;
    logic          ld_conflict_o;

    logic          dc_wr_o;
    logic [AW-1:0] dc_addr_o;
    logic [31:0]   dc_data_o;
    logic [1:0]    dc_type_o;
    logic          dc_busy_i;

    logic [CW-1:0] count_o;
    logic          empty_o;
    logic          full_o;

    modport slave (
        input  st_valid_i, st_addr_i, st_data_i, st_type_i, ld_addr_i, dc_busy_i,
        output st_ready_o, ld_fwd_data_o, ld_fwd_mask_o, ld_conflict_o,
        output dc_wr_o, dc_addr_o, dc_data_o, dc_type_o, count_o, empty_o, full_o
    );

    modport master (
        output st_valid_i, st_addr_i, st_data_i, st_type_i, ld_addr_i, dc_busy_i,
        input  st_ready_o, ld_fwd_data_o, ld_fwd_mask_o, ld_conflict_o,
        input  dc_wr_o, dc_addr_o, dc_data_o, dc_type_o, count_o, empty_o, full_o
    );
endinterface

// File: rtl/store_buffer.sv
// FIFO store buffer draining oldest-first to the data cache, with load lookup over buffered stores.
// STB_FWD_EN defined: byte forwarding to loads; undefined: word-match conflict flag only.
module store_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    store_buffer_if.slave sb
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [AW-1:0]    addr_mem [DEPTH];
    logic [31:0]      data_mem [DEPTH];
    logic [1:0]       type_mem [DEPTH];

    logic [DEPTH-1:0] valid_reg, valid_next;
    logic [PW-1:0]    head_reg, head_next;
    logic [PW-1:0]    tail_reg, tail_next;
    logic [CW-1:0]    count_reg, count_next;

    logic             full;
    logic             empty;
    logic             enq;
    logic             deq;
    logic [DEPTH-1:0] hit;
    logic             unused_ld_low;

    assign full  = (count_reg == CW'(DEPTH));
    assign empty = (count_reg == '0);
    // Ready never looks at a same-cycle dequeue, so a full buffer always stalls MEM.
    assign enq   = sb.st_valid_i && !full;
    assign deq   = !empty && !sb.dc_busy_i;

    assign sb.st_ready_o = !full;
    assign sb.full_o     = full;
    assign sb.empty_o    = empty;
    assign sb.count_o    = count_reg;
    assign sb.dc_wr_o    = !empty;
    assign sb.dc_addr_o  = addr_mem[head_reg];
    assign sb.dc_data_o  = data_mem[head_reg];
    assign sb.dc_type_o  = type_mem[head_reg];

    assign unused_ld_low = ^sb.ld_addr_i[1:0];

    always_comb begin
        valid_next = valid_reg;
        head_next  = head_reg;
        tail_next  = tail_reg;
        if (enq) begin
            valid_next[tail_reg] = 1'b1;
            tail_next            = tail_reg + PW'(1);
        end
        if (deq) begin
            valid_next[head_reg] = 1'b0;
            head_next            = head_reg + PW'(1);
        end
        count_next = count_reg + CW'(enq) - CW'(deq);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_reg <= '0;
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else begin
            valid_reg <= valid_next;
            head_reg  <= head_next;
            tail_reg  <= tail_next;
            count_reg <= count_next;
        end
    end

    // Payload needs no reset: nothing reads an entry whose valid bit is clear.
    always_ff @(posedge clk) begin
        if (enq) begin
            addr_mem[tail_reg] <= sb.st_addr_i;
            data_mem[tail_reg] <= sb.st_data_i;
            type_mem[tail_reg] <= sb.st_type_i;
        end
    end

    // Word-address match per entry; excludes the store being written this cycle.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_hit
        assign hit[gi] = valid_reg[gi] && (addr_mem[gi][AW-1:2] == sb.ld_addr_i[AW-1:2]);
    end

`ifdef STB_FWD_EN
    logic [3:0]  mask_mem [DEPTH];
    logic [31:0] lane_mem [DEPTH];
    logic [3:0]  enq_mask;
    logic [31:0] enq_lane;
    logic [3:0]  fwd_mask;
    logic [31:0] fwd_data;
    logic [PW-1:0] idx;

    always_comb begin
        enq_mask = 4'b1111;
        enq_lane = sb.st_data_i;
        case (sb.st_type_i)
            2'b01: begin
                if (sb.st_addr_i[1]) begin
                    enq_mask = 4'b1100;
                    enq_lane = {sb.st_data_i[15:0], 16'h0000};
                end else begin
                    enq_mask = 4'b0011;
                    enq_lane = {16'h0000, sb.st_data_i[15:0]};
                end
            end
            2'b10: begin
                enq_mask = 4'b0001 << sb.st_addr_i[1:0];
                enq_lane = {24'h000000, sb.st_data_i[7:0]} << {sb.st_addr_i[1:0], 3'b000};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            mask_mem[tail_reg] <= enq_mask;
            lane_mem[tail_reg] <= enq_lane;
        end
    end

    // Walk oldest to youngest so each younger hit overwrites the lanes it covers.
    always_comb begin
        fwd_mask = '0;
        fwd_data = '0;
        idx      = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head_reg + PW'(k);
            if (hit[idx]) begin
                for (int b = 0; b < 4; b++) begin
                    if (mask_mem[idx][b]) begin
                        fwd_mask[b]         = 1'b1;
                        fwd_data[8*b +: 8]  = lane_mem[idx][8*b +: 8];
                    end
                end
            end
        end
    end

    assign sb.ld_fwd_mask_o = fwd_mask;
    assign sb.ld_fwd_data_o = fwd_data;
    assign sb.ld_conflict_o = 1'b0;
`else
    assign sb.ld_fwd_mask_o = 4'b0000;
    assign sb.ld_fwd_data_o = 32'h0000_0000;
    assign sb.ld_conflict_o = |hit;
`endif

endmodule

// File: tb/tb_store_buffer.sv
// Scoreboard bench for store_buffer: enqueued stores are queued, drained cache writes popped and compared.
module tb_store_buffer;
    localparam int DEPTH = 4;
    localparam int AW    = 32;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    store_buffer_if #(.AW(AW), .DEPTH(DEPTH)) bus ();

    store_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sb    (bus)
    );

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [1:0]  typ;
    } wr_t;

    wr_t sb_q[$];
    int  checks   = 0;
    int  failures = 0;

    // Monitor away from the active edge: handshakes seen here complete at the next rising edge.
    always @(negedge clk) begin
        wr_t exp_wr;
        wr_t got_wr;
        if (!rst_n) begin
            sb_q.delete();
        end else begin
            checks++;
            if (bus.count_o !== CW'(sb_q.size())) begin
                failures++;
                $display("FAIL occupancy: count_o=%0d expected=%0d", bus.count_o, sb_q.size());
            end
            checks++;
            if (bus.dc_wr_o !== (sb_q.size() != 0)) begin
                failures++;
                $display("FAIL dc_wr: dc_wr_o=%b expected=%b", bus.dc_wr_o, sb_q.size() != 0);
            end
            if (bus.dc_wr_o === 1'b1 && bus.dc_busy_i === 1'b0 && sb_q.size() != 0) begin
                exp_wr = sb_q.pop_front();
                got_wr = '{addr: bus.dc_addr_o, data: bus.dc_data_o, typ: bus.dc_type_o};
                $display("drain addr=%h data=%h type=%0d", got_wr.addr, got_wr.data, got_wr.typ);
                checks++;
                if (got_wr !== exp_wr) begin
                    failures++;
                    $display("FAIL drain_order: got addr=%h data=%h type=%0d expected addr=%h data=%h type=%0d",
                             got_wr.addr, got_wr.data, got_wr.typ, exp_wr.addr, exp_wr.data, exp_wr.typ);
                end
            end
            if (bus.st_valid_i === 1'b1 && bus.st_ready_o === 1'b1) begin
                sb_q.push_back('{addr: bus.st_addr_i, data: bus.st_data_i, typ: bus.st_type_i});
                $display("enqueue addr=%h data=%h type=%0d", bus.st_addr_i, bus.st_data_i, bus.st_type_i);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] t);
        bus.st_valid_i = 1'b1;
        bus.st_addr_i  = a;
        bus.st_data_i  = d;
        bus.st_type_i  = t;
        tick();
        bus.st_valid_i = 1'b0;
    endtask

    task automatic drain();
        bus.dc_busy_i = 1'b0;
        for (int i = 0; i < 20 && bus.empty_o !== 1'b1; i++) tick();
    endtask

    task automatic test_reset();
        bus.st_valid_i = 1'b0;
        bus.st_addr_i  = '0;
        bus.st_data_i  = '0;
        bus.st_type_i  = 2'b00;
        bus.ld_addr_i  = '0;
        bus.dc_busy_i  = 1'b0;
        rst_n = 1'b0;
        repeat (2) tick();
        checks++; if (bus.dc_wr_o !== 1'b0)       begin failures++; $display("FAIL reset_dc_wr: got=%b want=0", bus.dc_wr_o); end
        checks++; if (bus.empty_o !== 1'b1)       begin failures++; $display("FAIL reset_empty: got=%b want=1", bus.empty_o); end
        checks++; if (bus.full_o !== 1'b0)        begin failures++; $display("FAIL reset_full: got=%b want=0", bus.full_o); end
        checks++; if (bus.st_ready_o !== 1'b1)    begin failures++; $display("FAIL reset_ready: got=%b want=1", bus.st_ready_o); end
        checks++; if (bus.ld_fwd_mask_o !== 4'h0) begin failures++; $display("FAIL reset_mask: got=%b want=0000", bus.ld_fwd_mask_o); end
        checks++; if (bus.ld_conflict_o !== 1'b0) begin failures++; $display("FAIL reset_conflict: got=%b want=0", bus.ld_conflict_o); end
        checks++; if (bus.count_o !== '0)         begin failures++; $display("FAIL reset_count: got=%0d want=0", bus.count_o); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        bus.dc_busy_i = 1'b0;
        checks++; if (bus.dc_wr_o !== 1'b0) begin failures++; $display("FAIL single_idle: dc_wr_o=%b want=0", bus.dc_wr_o); end
        store(32'h100, 32'hDEADBEEF, 2'b00);
        checks++; if (bus.dc_wr_o !== 1'b1)          begin failures++; $display("FAIL single_wr: got=%b want=1", bus.dc_wr_o); end
        checks++; if (bus.dc_addr_o !== 32'h100)     begin failures++; $display("FAIL single_addr: got=%h want=00000100", bus.dc_addr_o); end
        checks++; if (bus.dc_data_o !== 32'hDEADBEEF) begin failures++; $display("FAIL single_data: got=%h want=deadbeef", bus.dc_data_o); end
        checks++; if (bus.dc_type_o !== 2'b00)       begin failures++; $display("FAIL single_type: got=%b want=00", bus.dc_type_o); end
        tick();
        checks++; if (bus.empty_o !== 1'b1) begin failures++; $display("FAIL single_empty: got=%b want=1", bus.empty_o); end
    endtask

    task automatic test_full();
        bus.dc_busy_i = 1'b1;
        for (int i = 0; i < DEPTH; i++) store(32'h400 + 32'(4 * i), 32'hA000_0000 + 32'(i), 2'(i));
        checks++; if (bus.full_o !== 1'b1)     begin failures++; $display("FAIL full_flag: got=%b want=1", bus.full_o); end
        checks++; if (bus.st_ready_o !== 1'b0) begin failures++; $display("FAIL full_ready: got=%b want=0", bus.st_ready_o); end
        store(32'h500, 32'h5555_5555, 2'b00);
        checks++; if (bus.count_o !== CW'(DEPTH)) begin failures++; $display("FAIL full_reject: count=%0d want=%0d", bus.count_o, DEPTH); end
        checks++; if (bus.dc_addr_o !== 32'h400)  begin failures++; $display("FAIL busy_hold: dc_addr=%h want=00000400", bus.dc_addr_o); end
        bus.dc_busy_i = 1'b0;
        repeat (DEPTH - 1) tick();
        checks++; if (bus.dc_addr_o !== 32'h40C) begin failures++; $display("FAIL full_last: dc_addr=%h want=0000040c", bus.dc_addr_o); end
        tick();
        checks++; if (bus.empty_o !== 1'b1) begin failures++; $display("FAIL full_drain: empty=%b want=1", bus.empty_o); end
    endtask

    task automatic test_forward_byte();
        bus.dc_busy_i = 1'b1;
        store(32'h200, 32'h11223344, 2'b00);
        store(32'h201, 32'h000000AA, 2'b10);
        bus.ld_addr_i = 32'h200;
        #1;
`ifdef STB_FWD_EN
        checks++; if (bus.ld_fwd_mask_o !== 4'b1111)     begin failures++; $display("FAIL fwd_byte_mask: got=%b want=1111", bus.ld_fwd_mask_o); end
        checks++; if (bus.ld_fwd_data_o !== 32'h1122AA44) begin failures++; $display("FAIL fwd_byte_data: got=%h want=1122aa44", bus.ld_fwd_data_o); end
        checks++; if (bus.ld_conflict_o !== 1'b0)        begin failures++; $display("FAIL fwd_byte_conflict: got=%b want=0", bus.ld_conflict_o); end
`else
        checks++; if (bus.ld_fwd_mask_o !== 4'b0000) begin failures++; $display("FAIL fwd_byte_mask: got=%b want=0000", bus.ld_fwd_mask_o); end
        checks++; if (bus.ld_fwd_data_o !== 32'h0)   begin failures++; $display("FAIL fwd_byte_data: got=%h want=00000000", bus.ld_fwd_data_o); end
        checks++; if (bus.ld_conflict_o !== 1'b1)    begin failures++; $display("FAIL fwd_byte_conflict: got=%b want=1", bus.ld_conflict_o); end
`endif
        bus.ld_addr_i = 32'h204;
        #1;
        checks++; if (bus.ld_fwd_mask_o !== 4'b0000) begin failures++; $display("FAIL fwd_miss_mask: got=%b want=0000", bus.ld_fwd_mask_o); end
        checks++; if (bus.ld_conflict_o !== 1'b0)    begin failures++; $display("FAIL fwd_miss_conflict: got=%b want=0", bus.ld_conflict_o); end
        drain();
        checks++; if (bus.empty_o !== 1'b1) begin failures++; $display("FAIL fwd_byte_drain: empty=%b want=1", bus.empty_o); end
    endtask

    task automatic test_forward_half();
        logic [3:0]  want_mask;
        logic [31:0] want_data;
        logic        want_conf;
        bus.dc_busy_i  = 1'b1;
        bus.ld_addr_i  = 32'h300;
        bus.st_valid_i = 1'b1;
        bus.st_addr_i  = 32'h302;
        bus.st_data_i  = 32'h1234BEEF;
        bus.st_type_i  = 2'b01;
        #1;
        // Store in flight this cycle is not yet visible to the lookup.
        checks++; if (bus.ld_fwd_mask_o !== 4'b0000) begin failures++; $display("FAIL half_samecycle_mask: got=%b want=0000", bus.ld_fwd_mask_o); end
        checks++; if (bus.ld_conflict_o !== 1'b0)    begin failures++; $display("FAIL half_samecycle_conflict: got=%b want=0", bus.ld_conflict_o); end
        tick();
        bus.st_valid_i = 1'b0;
`ifdef STB_FWD_EN
        want_mask = 4'b1100; want_data = 32'hBEEF0000; want_conf = 1'b0;
`else
        want_mask = 4'b0000; want_data = 32'h0; want_conf = 1'b1;
`endif
        checks++; if (bus.ld_fwd_mask_o !== want_mask) begin failures++; $display("FAIL half_mask: got=%b want=%b", bus.ld_fwd_mask_o, want_mask); end
        checks++; if (bus.ld_fwd_data_o !== want_data) begin failures++; $display("FAIL half_data: got=%h want=%h", bus.ld_fwd_data_o, want_data); end
        checks++; if (bus.ld_conflict_o !== want_conf) begin failures++; $display("FAIL half_conflict: got=%b want=%b", bus.ld_conflict_o, want_conf); end
        store(32'h300, 32'h00000055, 2'b10);
        bus.dc_busy_i = 1'b0;
        #1;
`ifdef STB_FWD_EN
        want_mask = 4'b1101; want_data = 32'hBEEF0055; want_conf = 1'b0;
`endif
        // Head is being dequeued this cycle but still participates in the lookup.
        checks++; if (bus.ld_fwd_mask_o !== want_mask) begin failures++; $display("FAIL merge_mask: got=%b want=%b", bus.ld_fwd_mask_o, want_mask); end
        checks++; if (bus.ld_fwd_data_o !== want_data) begin failures++; $display("FAIL merge_data: got=%h want=%h", bus.ld_fwd_data_o, want_data); end
        checks++; if (bus.ld_conflict_o !== want_conf) begin failures++; $display("FAIL merge_conflict: got=%b want=%b", bus.ld_conflict_o, want_conf); end
        tick();
`ifdef STB_FWD_EN
        want_mask = 4'b0001; want_data = 32'h00000055;
`endif
        checks++; if (bus.ld_fwd_mask_o !== want_mask) begin failures++; $display("FAIL after_head_mask: got=%b want=%b", bus.ld_fwd_mask_o, want_mask); end
        checks++; if (bus.ld_fwd_data_o !== want_data) begin failures++; $display("FAIL after_head_data: got=%h want=%h", bus.ld_fwd_data_o, want_data); end
        checks++; if (bus.ld_conflict_o !== want_conf) begin failures++; $display("FAIL after_head_conflict: got=%b want=%b", bus.ld_conflict_o, want_conf); end
        drain();
        checks++; if (bus.ld_conflict_o !== 1'b0) begin failures++; $display("FAIL half_drained_conflict: got=%b want=0", bus.ld_conflict_o); end
        checks++; if (bus.ld_fwd_mask_o !== 4'b0000) begin failures++; $display("FAIL half_drained_mask: got=%b want=0000", bus.ld_fwd_mask_o); end
    endtask

    task automatic test_back_to_back();
        bus.dc_busy_i = 1'b1;
        store(32'h600, 32'h0000_0600, 2'b00);
        store(32'h604, 32'h0000_0604, 2'b00);
        checks++; if (bus.count_o !== CW'(2)) begin failures++; $display("FAIL b2b_pre_count: got=%0d want=2", bus.count_o); end
        bus.dc_busy_i = 1'b0;
        store(32'h608, 32'h0000_0608, 2'b00);
        bus.dc_busy_i = 1'b1;
        checks++; if (bus.count_o !== CW'(2))    begin failures++; $display("FAIL b2b_count: got=%0d want=2", bus.count_o); end
        checks++; if (bus.dc_addr_o !== 32'h604) begin failures++; $display("FAIL b2b_head: got=%h want=00000604", bus.dc_addr_o); end
        drain();
        checks++; if (bus.empty_o !== 1'b1) begin failures++; $display("FAIL b2b_drain: empty=%b want=1", bus.empty_o); end
    endtask

    task automatic test_async_reset();
        bus.dc_busy_i = 1'b1;
        for (int i = 0; i < 3; i++) store(32'h700 + 32'(4 * i), 32'h7000_0000 + 32'(i), 2'b00);
        checks++; if (bus.count_o !== CW'(3)) begin failures++; $display("FAIL areset_pre_count: got=%0d want=3", bus.count_o); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (bus.count_o !== '0)      begin failures++; $display("FAIL areset_count: got=%0d want=0", bus.count_o); end
        checks++; if (bus.empty_o !== 1'b1)    begin failures++; $display("FAIL areset_empty: got=%b want=1", bus.empty_o); end
        checks++; if (bus.dc_wr_o !== 1'b0)    begin failures++; $display("FAIL areset_dc_wr: got=%b want=0", bus.dc_wr_o); end
        checks++; if (bus.st_ready_o !== 1'b1) begin failures++; $display("FAIL areset_ready: got=%b want=1", bus.st_ready_o); end
        tick();
        rst_n = 1'b1;
        bus.dc_busy_i = 1'b0;
        tick();
        checks++; if (bus.empty_o !== 1'b1) begin failures++; $display("FAIL areset_no_drain: empty=%b want=1", bus.empty_o); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_single();
        test_full();
        test_forward_byte();
        test_forward_half();
        test_back_to_back();
        test_async_reset();
        repeat (2) tick();
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL leftover: pending expected writes=%0d want=0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
